// File: rtl/physics_pkg.sv
// Shared types and helpers for the soft-body physics pipeline stages.
package physics_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Two guard bits above the spring-count growth keep +F/-F sums exact.
  function automatic int acc_width(input int force_w, input int num_springs);
    return force_w + $clog2(num_springs) + 2;
  endfunction

  // Clamp a signed value into the range of a w-bit signed number.
  function automatic logic signed [31:0] sat(input logic signed [31:0] x, input int w);
    logic signed [31:0] hi, lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/spring_force_engine_if.sv
// Request/result bundle between node state, the spring-force engine and the integrator.
interface spring_force_engine_if #(
  parameter int NUM_SPRINGS   = 3,
  parameter int NUM_NODES     = 3,
  parameter int POSITION_SIZE = 8,
  parameter int VELOCITY_SIZE = 8,
  parameter int FORCE_SIZE    = 8
);
  localparam int IDX_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;

  logic                                                 input_valid;
  logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0]         nodes;
  logic [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0]         velocities;
  logic [1:0][NUM_SPRINGS-1:0][IDX_W-1:0]               springs;
  logic [1:0][NUM_SPRINGS-1:0][POSITION_SIZE-1:0]       spring_rest;
  logic [NUM_SPRINGS-1:0][2:0]                          spring_k;
  logic [NUM_SPRINGS-1:0]                               spring_en;
  logic [1:0][NUM_NODES-1:0][FORCE_SIZE-1:0]            spring_forces;
  logic                                                 output_valid;
  logic                                                 busy;
  logic                                                 index_error;

  modport master (
    output input_valid, nodes, velocities, springs, spring_rest, spring_k, spring_en,
    input  spring_forces, output_valid, busy, index_error
  );

  modport slave (
    input  input_valid, nodes, velocities, springs, spring_rest, spring_k, spring_en,
    output spring_forces, output_valid, busy, index_error
  );
endinterface

// File: rtl/spring_force_engine_spring_term.sv
// Per-spring force term: registered differences, then combinational shift/sum/saturate.
module spring_term
  import physics_pkg::*;
#(
  parameter int NUM_NODES     = 3,
  parameter int POSITION_SIZE = 8,
  parameter int VELOCITY_SIZE = 8,
  parameter int FORCE_SIZE    = 8,
  parameter int DAMP_SHIFT    = 2,
  parameter int IDX_W         = 2
) (
  input  logic                                          clk_in,
  input  logic                                          rst_in,
  input  logic                                          issue_i,
  input  logic                                          en_i,
  input  logic [IDX_W-1:0]                              a_i,
  input  logic [IDX_W-1:0]                              b_i,
  input  logic [1:0][POSITION_SIZE-1:0]                 rest_i,
  input  logic [2:0]                                    k_i,
  input  logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0]  nodes_i,
  input  logic [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0]  vel_i,
  output logic                                          vld_o,
  output logic                                          err_o,
  output logic [IDX_W-1:0]                              a_o,
  output logic [IDX_W-1:0]                              b_o,
  output logic [1:0][FORCE_SIZE-1:0]                    f_o
);
  localparam int DW  = POSITION_SIZE + 1;
  localparam int EW  = POSITION_SIZE + 2;
  localparam int DVW = VELOCITY_SIZE + 1;
  localparam int SW  = ((EW > DVW) ? EW : DVW) + 1;

  logic                    in_rng;
  logic [IDX_W-1:0]        a_sel, b_sel;
  logic [1:0][DW-1:0]      d;
  logic [1:0][EW-1:0]      e_d, e_q;
  logic [1:0][DVW-1:0]     dv_d, dv_q;
  logic [IDX_W-1:0]        a_q, b_q;
  logic [2:0]              k_q;
  logic                    vld_d, vld_q, err_d, err_q;

  // Out-of-range indices are steered to node 0 so the mux never reads past the array.
  always_comb begin
    in_rng = (int'(a_i) < NUM_NODES) && (int'(b_i) < NUM_NODES);
    a_sel  = in_rng ? a_i : '0;
    b_sel  = in_rng ? b_i : '0;
    vld_d  = issue_i & en_i & in_rng;
    err_d  = issue_i & en_i & ~in_rng;
    d      = '0;
    e_d    = '0;
    dv_d   = '0;
    for (int c = 0; c < 2; c++) begin
      d[c]    = DW'($signed(nodes_i[c][b_sel])) - DW'($signed(nodes_i[c][a_sel]));
      e_d[c]  = EW'($signed(d[c])) - EW'($signed(rest_i[c]));
      dv_d[c] = DVW'($signed(vel_i[c][b_sel])) - DVW'($signed(vel_i[c][a_sel]));
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      e_q   <= '0;
      dv_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      k_q   <= '0;
      vld_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      e_q   <= e_d;
      dv_q  <= dv_d;
      a_q   <= a_sel;
      b_q   <= b_sel;
      k_q   <= k_i;
      vld_q <= vld_d;
      err_q <= err_d;
    end
  end

  for (genvar c = 0; c < 2; c++) begin : g_axis
    logic signed [EW-1:0]  es;
    logic signed [DVW-1:0] dvs;
    logic signed [SW-1:0]  sum;
    assign es     = $signed(e_q[c]) >>> k_q;
    assign dvs    = $signed(dv_q[c]) >>> DAMP_SHIFT;
    assign sum    = SW'(es) + SW'(dvs);
    assign f_o[c] = FORCE_SIZE'(sat(32'(sum), FORCE_SIZE));
  end

  assign vld_o = vld_q;
  assign err_o = err_q;
  assign a_o   = a_q;
  assign b_o   = b_q;

endmodule

// File: rtl/spring_force_engine.sv
// Spring-force stage: walks the spring list one per clock and accumulates +F/-F per node.
module spring_force_engine
  import physics_pkg::*;
#(
  parameter int NUM_SPRINGS   = 3,
  parameter int NUM_NODES     = 3,
  parameter int POSITION_SIZE = 8,
  parameter int VELOCITY_SIZE = 8,
  parameter int FORCE_SIZE    = 8,
  parameter int DAMP_SHIFT    = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  spring_force_engine_if.slave bus
);
  localparam int IDX_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam int CNT_W = (NUM_SPRINGS > 1) ? $clog2(NUM_SPRINGS) : 1;
  localparam int ACC_W = acc_width(FORCE_SIZE, NUM_SPRINGS);

  state_e                                     state_q, state_d;
  logic [CNT_W-1:0]                           cnt_q, cnt_d;
  logic [1:0][NUM_NODES-1:0][ACC_W-1:0]       acc_q, acc_d;
  logic                                       err_q, err_d;
  logic [1:0][NUM_NODES-1:0][FORCE_SIZE-1:0]  frc_q, frc_d;
  logic                                       ovld_q, ovld_d;
  logic                                       ierr_q, ierr_d;

  logic busy, issue, clr, done;

  logic                          term_vld, term_err;
  logic [IDX_W-1:0]              term_a, term_b;
  logic [1:0][FORCE_SIZE-1:0]    term_f;
  logic [1:0][ACC_W-1:0]         f_ext;
  logic [1:0][POSITION_SIZE-1:0] rest_sel;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (bus.input_valid) state_d = ST_CLEAR;
      ST_CLEAR: state_d = ST_RUN;
      ST_RUN:   if (cnt_q == CNT_W'(NUM_SPRINGS - 1)) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q != ST_IDLE);
    issue = (state_q == ST_RUN);
    clr   = (state_q == ST_CLEAR);
    done  = (state_q == ST_DONE);
  end

  always_comb begin
    rest_sel[0] = bus.spring_rest[0][cnt_q];
    rest_sel[1] = bus.spring_rest[1][cnt_q];
  end

  spring_term #(
    .NUM_NODES    (NUM_NODES),
    .POSITION_SIZE(POSITION_SIZE),
    .VELOCITY_SIZE(VELOCITY_SIZE),
    .FORCE_SIZE   (FORCE_SIZE),
    .DAMP_SHIFT   (DAMP_SHIFT),
    .IDX_W        (IDX_W)
  ) u_term (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .issue_i(issue),
    .en_i   (bus.spring_en[cnt_q]),
    .a_i    (bus.springs[0][cnt_q]),
    .b_i    (bus.springs[1][cnt_q]),
    .rest_i (rest_sel),
    .k_i    (bus.spring_k[cnt_q]),
    .nodes_i(bus.nodes),
    .vel_i  (bus.velocities),
    .vld_o  (term_vld),
    .err_o  (term_err),
    .a_o    (term_a),
    .b_o    (term_b),
    .f_o    (term_f)
  );

  always_comb begin
    for (int c = 0; c < 2; c++) f_ext[c] = ACC_W'($signed(term_f[c]));
  end

  // a == b adds and subtracts the same F, so self-springs cancel without a special case.
  always_comb begin
    acc_d  = acc_q;
    err_d  = err_q;
    cnt_d  = cnt_q;
    frc_d  = frc_q;
    ierr_d = ierr_q;
    ovld_d = 1'b0;
    if (clr) begin
      acc_d = '0;
      err_d = 1'b0;
      cnt_d = '0;
    end
    if (issue) cnt_d = cnt_q + 1'b1;
    if (term_err) err_d = 1'b1;
    if (term_vld) begin
      for (int c = 0; c < 2; c++) begin
        for (int n = 0; n < NUM_NODES; n++) begin
          acc_d[c][n] = acc_q[c][n]
                      + ((term_a == IDX_W'(n)) ? f_ext[c] : '0)
                      - ((term_b == IDX_W'(n)) ? f_ext[c] : '0);
        end
      end
    end
    if (done) begin
      for (int c = 0; c < 2; c++) begin
        for (int n = 0; n < NUM_NODES; n++) begin
          frc_d[c][n] = FORCE_SIZE'(sat(32'($signed(acc_q[c][n])), FORCE_SIZE));
        end
      end
      ierr_d = err_q;
      ovld_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      err_q  <= 1'b0;
      frc_q  <= '0;
      ovld_q <= 1'b0;
      ierr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      err_q  <= err_d;
      frc_q  <= frc_d;
      ovld_q <= ovld_d;
      ierr_q <= ierr_d;
    end
  end

  assign bus.spring_forces = frc_q;
  assign bus.output_valid  = ovld_q;
  assign bus.busy          = busy;
  assign bus.index_error   = ierr_q;

endmodule

// File: tb/tb_spring_force_engine.sv
// Directed bench for spring_force_engine with hand-computed force vectors.
module tb_spring_force_engine;
  localparam int NS = 3;
  localparam int NN = 3;
  localparam int PS = 8;
  localparam int VS = 8;
  localparam int FS = 8;
  localparam int DS = 2;
  localparam int IW = 2;

  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

  spring_force_engine_if #(
    .NUM_SPRINGS(NS), .NUM_NODES(NN), .POSITION_SIZE(PS),
    .VELOCITY_SIZE(VS), .FORCE_SIZE(FS)
  ) bus ();

  spring_force_engine #(
    .NUM_SPRINGS(NS), .NUM_NODES(NN), .POSITION_SIZE(PS),
    .VELOCITY_SIZE(VS), .FORCE_SIZE(FS), .DAMP_SHIFT(DS)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (bus)
  );

  int errs   = 0;
  int checks = 0;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_node(input int n, input int px, input int py, input int vx, input int vy);
    bus.nodes[0][n]      = PS'(px);
    bus.nodes[1][n]      = PS'(py);
    bus.velocities[0][n] = VS'(vx);
    bus.velocities[1][n] = VS'(vy);
  endtask

  task automatic default_nodes();
    set_node(0, 3, 4, 1, 2);
    set_node(1, 6, 8, -2, -3);
    set_node(2, 12, -2, 5, 8);
  endtask

  task automatic set_spring(input int s, input int a, input int b, input int rx, input int ry,
                            input int k, input logic en);
    bus.springs[0][s]     = IW'(a);
    bus.springs[1][s]     = IW'(b);
    bus.spring_rest[0][s] = PS'(rx);
    bus.spring_rest[1][s] = PS'(ry);
    bus.spring_k[s]       = 3'(k);
    bus.spring_en[s]      = en;
  endtask

  task automatic clear_springs();
    for (int s = 0; s < NS; s++) set_spring(s, 0, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic chk_forces(input string tag, input int x0, input int y0, input int x1,
                            input int y1, input int x2, input int y2);
    int ex [2][NN];
    ex[0][0] = x0; ex[1][0] = y0;
    ex[0][1] = x1; ex[1][1] = y1;
    ex[0][2] = x2; ex[1][2] = y2;
    for (int n = 0; n < NN; n++)
      for (int c = 0; c < 2; c++)
        check($sformatf("%s n%0d.%s", tag, n, (c == 0) ? "x" : "y"),
              $signed(bus.spring_forces[c][n]), ex[c][n]);
  endtask

  // Launch one calculation and wait (bounded) for the result pulse.
  task automatic run_calc(input string tag);
    int lat;
    @(negedge clk_in);
    bus.input_valid = 1'b1;
    @(posedge clk_in);
    #1;
    bus.input_valid = 1'b0;
    check({tag, " busy"}, bus.busy, 1);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk_in);
      #1;
      if (bus.output_valid) begin
        lat = i;
        break;
      end
    end
    check({tag, " latency"}, lat, NS + 3);
    check({tag, " busy_done"}, bus.busy, 0);
    @(posedge clk_in);
    #1;
    check({tag, " pulse_width"}, bus.output_valid, 0);
  endtask

  initial begin
    int first, second, npulse;

    rst_in          = 1'b0;
    bus.input_valid = 1'b0;
    default_nodes();
    clear_springs();
    repeat (2) @(posedge clk_in);
    #1;
    check("reset busy", bus.busy, 0);
    check("reset output_valid", bus.output_valid, 0);
    check("reset index_error", bus.index_error, 0);
    chk_forces("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk_in);
    rst_in = 1'b1;

    // Single spring 0->1: e=(3,4), dv=(-3,-5)>>>2=(-1,-2) -> F=(2,2).
    set_spring(0, 0, 1, 0, 0, 0, 1'b1);
    run_calc("single");
    check("single index_error", bus.index_error, 0);
    chk_forces("single", 2, 2, -2, -2, 0, 0);

    // F0=(2,2), F1 (1->2,rest(2,-4),k1)=(3,-1), F2 (2->0,k2)=(-4,-1).
    set_spring(1, 1, 2, 2, -4, 1, 1'b1);
    set_spring(2, 2, 0, 0, 0, 2, 1'b1);
    run_calc("three");
    check("three index_error", bus.index_error, 0);
    chk_forces("three", 6, 3, 1, -3, -7, 0);

    clear_springs();
    set_spring(1, 1, 1, 5, -7, 0, 1'b1);
    run_calc("self");
    check("self index_error", bus.index_error, 0);
    chk_forces("self", 0, 0, 0, 0, 0, 0);

    // Load nonzero forces first so the error case proves it zeroes them.
    clear_springs();
    set_spring(0, 0, 1, 0, 0, 0, 1'b1);
    run_calc("preload");
    chk_forces("preload", 2, 2, -2, -2, 0, 0);
    set_spring(0, 0, 3, 0, 0, 0, 1'b1);
    run_calc("badidx");
    check("badidx index_error", bus.index_error, 1);
    chk_forces("badidx", 0, 0, 0, 0, 0, 0);
    set_spring(0, 0, 3, 0, 0, 0, 1'b0);
    run_calc("badidx_off");
    check("badidx_off index_error", bus.index_error, 0);

    set_node(0, -100, 0, 0, 0);
    set_node(1, 100, 0, 0, 0);
    set_node(2, 12, -2, 0, 0);
    clear_springs();
    set_spring(0, 0, 1, 0, 0, 0, 1'b1);
    run_calc("sat1");
    chk_forces("sat1", 127, 0, -127, 0, 0, 0);
    // Three saturated terms: +381 / -381 clamp at the output.
    set_spring(1, 0, 1, 0, 0, 0, 1'b1);
    set_spring(2, 0, 1, 0, 0, 0, 1'b1);
    run_calc("sat3");
    chk_forces("sat3", 127, 0, -128, 0, 0, 0);

    // Mixed: bad spring flags error, good 0->1 spring still contributes.
    default_nodes();
    clear_springs();
    set_spring(0, 0, 3, 0, 0, 0, 1'b1);
    set_spring(1, 0, 1, 0, 0, 0, 1'b1);
    first  = -1;
    second = -1;
    npulse = 0;
    @(negedge clk_in);
    bus.input_valid = 1'b1;
    @(posedge clk_in);
    #1;
    bus.input_valid = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk_in);
      #1;
      if (i == 2 || i == 7) bus.input_valid = 1'b0;
      if (bus.output_valid) begin
        npulse++;
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
      if (i == 1) bus.input_valid = 1'b1;
      if (i == 6) begin
        check("mixed index_error", bus.index_error, 1);
        chk_forces("mixed", 2, 2, -2, -2, 0, 0);
        bus.input_valid = 1'b1;
      end
      if (i == 7) check("b2b busy", bus.busy, 1);
    end
    check("ignore first pulse", first, 6);
    check("b2b second pulse", second, 13);
    check("pulse count", npulse, 2);

    // Reset in RUN: forces/error from the mixed case must clear at once.
    @(negedge clk_in);
    bus.input_valid = 1'b1;
    @(posedge clk_in);
    #1;
    bus.input_valid = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    #1;
    check("midrst busy", bus.busy, 0);
    check("midrst output_valid", bus.output_valid, 0);
    check("midrst index_error", bus.index_error, 0);
    chk_forces("midrst", 0, 0, 0, 0, 0, 0);
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    npulse = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_in);
      #1;
      if (bus.output_valid) npulse++;
    end
    check("midrst no pulse", npulse, 0);

    clear_springs();
    set_spring(0, 0, 1, 0, 0, 0, 1'b1);
    set_spring(1, 1, 2, 2, -4, 1, 1'b1);
    set_spring(2, 2, 0, 0, 0, 2, 1'b1);
    run_calc("after_rst");
    check("after_rst index_error", bus.index_error, 0);
    chk_forces("after_rst", 6, 3, 1, -3, -7, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
